// File: rtl/sad_pipe_pkg.sv
// ============================================================================
// Module      : sad_pipe_pkg
// Description : Shared constants and types for the SAD pipelined datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sad_pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic                  RegWrite;
    logic                  MemtoReg;
    logic [2:0]            LoadSize;
    logic [DEF_REG_AW-1:0] Rd;
  } wb_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/load_extender.sv
// ============================================================================
// Module      : load_extender
// Description : Selects a little-endian byte/halfword from a load word and
//               sign- or zero-extends it according to the load funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extender
  import sad_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        offset_i,
  input  logic [2:0]        size_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    // Halfwords are assumed aligned, so only the upper offset bit matters
    half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];
  end

  always_comb begin
    case (size_i)
      F3_LB:   data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: data_o = data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register with stall, flush, x0 write
//               suppression and forwarding tap. Define LOAD_EXT_EN to enable
//               byte/halfword load extension; otherwise loads are word-only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage
  import sad_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              InValid,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] AluResult,
  input  logic [REG_AW-1:0] Rd,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [2:0]        LoadSize,
  output logic              WbValid,
  output logic              WbRegWrite,
  output logic [REG_AW-1:0] WbRd,
  output logic [DATA_W-1:0] WbData,
  output logic              FwdValid
);

  wb_ctrl_t          ctrl;
  logic [DATA_W-1:0] load_data;

  logic              valid_d,    valid_q;
  logic              regwrite_d, regwrite_q;
  logic [REG_AW-1:0] rd_d,       rd_q;
  logic [DATA_W-1:0] data_d,     data_q;

  always_comb begin
    ctrl          = '0;
    ctrl.RegWrite = RegWrite;
    ctrl.MemtoReg = MemtoReg;
    ctrl.LoadSize = LoadSize;
    ctrl.Rd       = DEF_REG_AW'(Rd);
  end

`ifdef LOAD_EXT_EN
  load_extender #(
    .DATA_W   (DATA_W)
  ) u_load_extender (
    .data_i   (ReadData),
    .offset_i (AluResult[1:0]),
    .size_i   (ctrl.LoadSize),
    .data_o   (load_data)
  );
`else
  logic [2:0] unused_load_size;

  assign load_data        = ReadData;
  assign unused_load_size = ctrl.LoadSize;
`endif

  // Flush outranks stall so a squashed instruction never lingers in WB
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    data_d     = data_q;
    if (Flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = '0;
      data_d     = '0;
    end else if (!Stall) begin
      valid_d    = InValid;
      regwrite_d = InValid & ctrl.RegWrite & (ctrl.Rd != '0);
      rd_d       = REG_AW'(ctrl.Rd);
      data_d     = ctrl.MemtoReg ? load_data : AluResult;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end

  assign WbValid    = valid_q;
  assign WbRegWrite = regwrite_q;
  assign WbRd       = rd_q;
  assign WbData     = data_q;
  assign FwdValid   = valid_q & regwrite_q & (rd_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall, Flush, InValid;
  logic [31:0] ReadData, AluResult;
  logic [4:0]  Rd;
  logic        RegWrite, MemtoReg;
  logic [2:0]  LoadSize;
  logic        WbValid, WbRegWrite, FwdValid;
  logic [4:0]  WbRd;
  logic [31:0] WbData;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the register file should see next
  logic        m_valid, m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  mem_wb_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Stall      (Stall),
    .Flush      (Flush),
    .InValid    (InValid),
    .ReadData   (ReadData),
    .AluResult  (AluResult),
    .Rd         (Rd),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .LoadSize   (LoadSize),
    .WbValid    (WbValid),
    .WbRegWrite (WbRegWrite),
    .WbRd       (WbRd),
    .WbData     (WbData),
    .FwdValid   (FwdValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] addr,
                                           input logic [2:0] f3);
`ifdef LOAD_EXT_EN
    logic [31:0] v;
    case (f3)
      3'b000: begin v = w >> (8 * addr[1:0]); return 32'(signed'(v[7:0])); end
      3'b100: begin v = w >> (8 * addr[1:0]); return v & 32'hFF; end
      3'b001: begin v = w >> (addr[1] ? 16 : 0); return 32'(signed'(v[15:0])); end
      3'b101: begin v = w >> (addr[1] ? 16 : 0); return v & 32'hFFFF; end
      default: return w;
    endcase
`else
    return (addr == addr && f3 == f3) ? w : w;
`endif
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_we = 1'b0; m_rd = '0; m_data = '0;
  endtask

  task automatic model_edge();
    if (!rst_n || Flush) model_clear();
    else if (!Stall) begin
      m_valid = InValid;
      m_rd    = Rd;
      m_we    = InValid && RegWrite && (Rd != 0);
      m_data  = MemtoReg ? ref_load(ReadData, AluResult, LoadSize) : AluResult;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {31'b0, WbValid},    {31'b0, m_valid});
    check({tag, ".we"},    {31'b0, WbRegWrite}, {31'b0, m_we});
    check({tag, ".rd"},    {27'b0, WbRd},       {27'b0, m_rd});
    check({tag, ".data"},  WbData,              m_data);
    check({tag, ".fwd"},   {31'b0, FwdValid},   {31'b0, m_valid && m_we && (m_rd != 0)});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic [31:0] alu, input logic [2:0] sz);
    InValid = v; RegWrite = rw; MemtoReg = m2r; Rd = rd;
    ReadData = rdata; AluResult = alu; LoadSize = sz;
  endtask

  task automatic rand_in();
    set_in(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
           $urandom, $urandom, 3'($urandom));
  endtask

  task automatic ext_case(input string tag, input logic [1:0] off, input logic [2:0] sz,
                          input logic [31:0] exp_ext);
    set_in(1, 1, 1, 5'd3, 32'h80F1_7F82, {30'h100, off}, sz);
    cycle(tag);
`ifdef LOAD_EXT_EN
    check({tag, ".const"}, WbData, exp_ext);
`else
    check({tag, ".const"}, WbData, (exp_ext == exp_ext) ? 32'h80F1_7F82 : 32'h0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
    set_in(1, 1, 1, 5'd9, 32'hFFFF_FFFF, 32'h1234_5678, 3'b010);
    model_clear();
    #1;
    check_all("reset0");
    cycle("reset1");
    cycle("reset2");
    rst_n = 1'b1;

    // Word load path
    set_in(1, 1, 1, 5'd5, 32'hDEAD_BEEF, 32'h0000_0100, 3'b010);
    cycle("lw");
    check("lw.const", WbData, 32'hDEAD_BEEF);
    check("lw.fwd_const", {31'b0, FwdValid}, 32'd1);

    // ALU path targeting x0
    set_in(1, 1, 0, 5'd0, 32'h0, 32'h0000_0040, 3'b010);
    cycle("x0");
    check("x0.data_const", WbData, 32'h40);
    check("x0.we_const", {31'b0, WbRegWrite}, 32'd0);

    // Stall holds, then flush beats stall
    set_in(1, 1, 0, 5'd7, 32'h0, 32'h0000_0077, 3'b010);
    cycle("cap7");
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      cycle("stall");
      check("stall.rd_const", {27'b0, WbRd}, 32'd7);
    end
    Flush = 1'b1;
    cycle("flush");
    check("flush.data_const", WbData, 32'h0);
    Stall = 1'b0; Flush = 1'b0;

    // Asynchronous reset dropped mid-cycle while stalled
    set_in(1, 1, 0, 5'd9, 32'h0, 32'hCAFE_0000, 3'b010);
    cycle("pre_async");
    Stall = 1'b1;
    #3 rst_n = 1'b0;
    model_clear();
    #1;
    check_all("async");
    check("async.we_const", {31'b0, WbRegWrite}, 32'd0);
    cycle("async_hold");
    rst_n = 1'b1; Stall = 1'b0;

    ext_case("lb_off0",  2'd0, 3'b000, 32'hFFFF_FF82);
    ext_case("lbu_off1", 2'd1, 3'b100, 32'h0000_007F);
    ext_case("lh_off2",  2'd2, 3'b001, 32'hFFFF_80F1);
    ext_case("lhu_off0", 2'd0, 3'b101, 32'h0000_7F82);

    // Randomized traffic with occasional stall, flush and reset
    for (int i = 0; i < 400; i++) begin
      rand_in();
      Stall = ($urandom_range(0, 4) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      if (rst_n && $urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all("rand_rst");
      end else if (!rst_n && $urandom_range(0, 1) == 0) begin
        rst_n = 1'b1;
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register of the SAD pipelined datapath.
- Sits directly downstream of the data memory. Captures the memory's combinational read data, the ALU result and the write-back control at the end of the MEM cycle.
- Presents the selected write-back value and register-file write controls to the WB stage one cycle later.
- Supports stall (hold), flush (bubble), x0 write suppression and a forwarding tap.

Parameters:
- DATA_W, 32, width of read data, ALU result and write-back data.
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Stall  input  1  hold all stage registers this cycle.
- Flush  input  1  load a bubble this cycle.
- InValid  input  1  MEM stage holds a real instruction.
- ReadData  input  DATA_W  data-memory read data, already 0 when MemRead=0.
- AluResult  input  DATA_W  EX/MEM ALU result; also the memory address.
- Rd  input  REG_AW  destination register.
- RegWrite  input  1  instruction writes the register file.
- MemtoReg  input  1  1 = write back memory data, 0 = write back ALU result.
- LoadSize  input  3  funct3 of the load (LB/LH/LW/LBU/LHU).
- WbValid  output  1  registered valid.
- WbRegWrite  output  1  qualified register-file write enable.
- WbRd  output  REG_AW  registered destination.
- WbData  output  DATA_W  write-back value.
- FwdValid  output  1  forwarding tap valid: WbValid & WbRegWrite & (WbRd != 0).

Behaviour:
- Reset: rst_n low asynchronously clears every output and internal register to 0 (WbValid=0, WbRegWrite=0, WbRd=0, WbData=0, FwdValid=0). Release is synchronous to the next clk edge; no capture occurs on the edge where rst_n is still low.
- Latency: exactly 1 cycle. Inputs sampled at posedge N appear on outputs after posedge N, stable until posedge N+1.
- Capture, no stall and no flush:
  - WbValid <= InValid.
  - WbRd <= Rd.
  - WbRegWrite <= InValid & RegWrite & (Rd != 0).
  - WbData <= MemtoReg ? LoadExt(ReadData) : AluResult.
- Stall=1, Flush=0: all registers hold their previous value.
- Flush=1: WbValid, WbRegWrite and WbRd load 0; WbData loads 0. Flush has priority over Stall when both are asserted.
- InValid=0 with no stall/flush: WbValid=0 and WbRegWrite=0. WbData and WbRd are still captured but are don't-care to the register file.
- x0 rule: Rd=0 never produces WbRegWrite=1, regardless of RegWrite.
- MemtoReg=1 with upstream MemRead=0: ReadData arrives as 0, so WbData=0. No error is flagged.
- FwdValid is purely combinational from the registered outputs; no extra latency.
- Reset asserted mid-stall: reset wins; after release the stage is empty (bubble).
- No internal state beyond the pipeline register. No FSM.

Optional Feature:
- Macro LOAD_EXT_EN.
- Defined: LoadExt selects the byte or halfword using AluResult[1:0], as registered alongside the data:
  - LB: sign-extend the byte.
  - LBU: zero-extend the byte.
  - LH: sign-extend the halfword; AluResult[1] selects the half.
  - LHU: zero-extend the halfword.
  - LW or any other code: pass the full word.
  - Byte lanes are little-endian.
- Undefined: LoadExt is identity (word loads only). The LoadSize port remains but is ignored; AluResult[1:0] is unused for data.

Decomposition:
- Shared package sad_pipe_pkg holds:
  - funct3 load constants: LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101.
  - DATA_W and REG_AW defaults.
  - The write-back control bundle typedef (RegWrite, MemtoReg, LoadSize, Rd).
- One natural sub-module, load_extender: combinational byte/halfword select and extension, instantiated only under LOAD_EXT_EN.

Test Plan:
- Reset and basic LW path:
  - Hold rst_n=0 with non-zero inputs -> all outputs 0.
  - Release; drive InValid=1, RegWrite=1, MemtoReg=1, Rd=5, ReadData=32'hDEADBEEF -> next cycle WbData=32'hDEADBEEF, WbRd=5, WbRegWrite=1, FwdValid=1.
- ALU path and x0:
  - MemtoReg=0, AluResult=32'h0000_0040, Rd=0, RegWrite=1 -> WbData=32'h40, WbRegWrite=0, FwdValid=0.
- Stall then flush:
  - Capture Rd=7.
  - Assert Stall for 3 cycles with changing inputs -> outputs frozen at Rd=7.
  - Assert Stall=1 and Flush=1 together -> next cycle WbValid=0, WbRegWrite=0, WbData=0.
- Async reset mid-operation:
  - Drop rst_n between clock edges while WbRegWrite=1 -> outputs go to 0 immediately, without waiting for clk.
- LOAD_EXT_EN, ReadData=32'h80F1_7F82:
  - LB at AluResult[1:0]=0 -> 32'hFFFF_FF82.
  - LBU at offset 1 -> 32'h0000_007F.
  - LH at offset 2 -> 32'hFFFF_80F1.
  - LHU at offset 0 -> 32'h0000_7F82.
  - With the macro undefined, every case -> 32'h80F1_7F82.
